// File: rtl/fb_mono_slave_if.sv
// if_wb: Wishbone bus bundle; dat_m carries initiator->target data, dat_s carries target->initiator data.
// Signals: cyc, stb, we, adr[31:0], sel[3:0], dat_m[31:0], dat_s[31:0], ack.
interface if_wb;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        ack;
   modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack);
   modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack);
endinterface

// File: rtl/fb_mono_slave.sv
// fb_mono_slave: 1 bpp framebuffer RAM behind a Wishbone slave, zeroed word by word after every reset.
// Ports: clk_i clock; rst_i synchronous active-high reset; bus Wishbone slave (dat_m write data in,
//        dat_s read data out); clr_busy high while the post-reset clear is running.
module fb_mono_slave #(
   parameter int AW    = 14,
   parameter int DEPTH = 9600
) (
   input  logic clk_i,
   input  logic rst_i,
   if_wb.slave  bus,
   output logic clr_busy
);
   localparam logic [1:0]    S_CLEAR = 2'd0;
   localparam logic [1:0]    S_IDLE  = 2'd1;
   localparam logic [1:0]    S_READ  = 2'd2;
   localparam logic [1:0]    S_ACK   = 2'd3;
   localparam logic [AW-1:0] L_LAST  = AW'(DEPTH - 1);

   logic [1:0]    r_state;
   logic [AW-1:0] r_clr_cnt;
   logic [AW-1:0] r_idx;
   logic          r_in;
   logic [31:0]   r_dat_o;
   logic [31:0]   r_mem [DEPTH];

   logic [AW-1:0] w_idx;
   logic          w_in;
   logic          w_req;
   logic          w_unused;

   assign w_idx    = bus.adr[AW+1:2];
   // upper address bits must be zero as well, so nothing above the RAM aliases into it
   assign w_in     = ~|bus.adr[31:AW+2] && w_idx <= L_LAST;
   assign w_unused = ^bus.adr[1:0];
   assign w_req    = r_state == S_IDLE && bus.cyc && bus.stb;
   // gating with cyc makes an initiator abort in S_ACK drop ack immediately
   assign bus.ack  = r_state == S_ACK && bus.cyc;
   assign bus.dat_s = r_dat_o;
   assign clr_busy = r_state == S_CLEAR;

   // single write port shared by the clear sweep and bus writes; bus writes commit on the latch edge
   always_ff @(posedge clk_i) begin
      if (r_state == S_CLEAR)
         r_mem[r_clr_cnt] <= '0;
      else if (w_req && bus.we && w_in)
         for (int b = 0; b < 4; b++)
            if (bus.sel[b]) r_mem[w_idx][8*b +: 8] <= bus.dat_m[8*b +: 8];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
         r_dat_o   <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_clr_cnt <= (r_clr_cnt == L_LAST) ? r_clr_cnt : r_clr_cnt + 1'b1;
               r_state   <= (r_clr_cnt == L_LAST) ? S_IDLE : S_CLEAR;
            end
            S_IDLE: if (w_req) begin
               r_idx   <= w_idx;
               r_in    <= w_in;
               r_state <= bus.we ? S_ACK : S_READ;
               if (bus.we) r_dat_o <= '0;
            end
            S_READ: begin
               r_state <= bus.cyc ? S_ACK : S_IDLE;
               if (bus.cyc) r_dat_o <= r_in ? r_mem[r_idx] : '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_mono_slave.sv
// tb_fb_mono_slave: table vectors, corner sequences and random traffic against a word-array model.
module tb_fb_mono_slave;
   localparam int AW    = 14;
   localparam int DEPTH = 9600;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic clr_busy;
   if_wb bus_if();

   fb_mono_slave #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus_if), .clr_busy(clr_busy)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   logic [31:0] mdl [DEPTH];

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;
   vec_t vt [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] adr);
      return (adr < 32'(4 * DEPTH)) ? mdl[adr / 4] : 32'h0;
   endfunction

   function automatic void ref_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      if (adr < 32'(4 * DEPTH))
         for (int b = 0; b < 4; b++)
            if (sel[b]) mdl[adr / 4][8*b +: 8] = dat[8*b +: 8];
   endfunction

   function automatic void ref_clear;
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
   endfunction

   // one complete transaction: stb for the latch cycle only, cyc held until ack
   task automatic xact(input bit we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       output logic [31:0] rd, output int lat, output bit one_shot);
      bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = we;
      bus_if.adr = adr; bus_if.sel = sel; bus_if.dat_m = dat;
      tick;
      bus_if.stb = 1'b0;
      bus_if.dat_m = $urandom;
      lat = 1;
      while (bus_if.ack !== 1'b1 && lat < 20) begin
         tick;
         lat++;
      end
      rd = bus_if.dat_s;
      tick;
      one_shot = bus_if.ack === 1'b0;
      bus_if.cyc = 1'b0;
   endtask

   task automatic op(input string nm, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
      logic [31:0] rd;
      logic [31:0] exp;
      int lat;
      bit os;
      exp = we ? 32'h0 : ref_read(adr);
      xact(we, adr, dat, sel, rd, lat, os);
      if (we) ref_write(adr, dat, sel);
      chk({nm, " data"}, rd, exp);
      chk({nm, " latency"}, 32'(lat), we ? 32'd1 : 32'd2);
      chk({nm, " ack width"}, 32'(os), 32'd1);
   endtask

   initial begin
      logic [31:0] rd, adr, hold;
      int lat, n, n_fall;
      bit os, saw_ack;
      bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
      bus_if.adr = '0; bus_if.sel = '0; bus_if.dat_m = '0;

      vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        1};
      vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADBEEF, 2};
      vt[2]  = '{1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'hF, 32'h0,        1};
      vt[3]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'h5, 32'h0,        1};
      vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'hFF22FF44, 2};
      vt[5]  = '{1'b0, 32'h0000_9600, 32'h0,        4'hF, 32'h0,        2};
      vt[6]  = '{1'b0, 32'h0001_0000, 32'h0,        4'hF, 32'h0,        2};
      vt[7]  = '{1'b1, 32'h0000_9600, 32'hA5A5A5A5, 4'hF, 32'h0,        1};
      vt[8]  = '{1'b0, 32'h0000_95FC, 32'h0,        4'hF, 32'h0,        2};
      vt[9]  = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h0,        2};
      vt[10] = '{1'b1, 32'h0004_0010, 32'hCAFEF00D, 4'hF, 32'h0,        1};
      vt[11] = '{1'b0, 32'h0000_0013, 32'h0,        4'hF, 32'hDEADBEEF, 2};
      vt[12] = '{1'b1, 32'h0000_95FC, 32'h12345678, 4'hF, 32'h0,        1};
      vt[13] = '{1'b0, 32'h0000_95FF, 32'h0,        4'hF, 32'h12345678, 2};
      vt[14] = '{1'b0, 32'h0004_0010, 32'h0,        4'hF, 32'h0,        2};
      vt[15] = '{1'b1, 32'h0000_0011, 32'h0000AB00, 4'h2, 32'h0,        1};
      vt[16] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'hDEADABEF, 2};

      tick; tick;
      chk("reset clr_busy", 32'(clr_busy), 32'd1);
      chk("reset ack", 32'(bus_if.ack), 32'd0);
      chk("reset dat_o", bus_if.dat_s, 32'h0);
      rst_i = 1'b0;
      n = 0; saw_ack = 1'b0;
      while (clr_busy !== 1'b0 && n < 20000) begin
         tick;
         n++;
         if (bus_if.ack !== 1'b0) saw_ack = 1'b1;
      end
      chk("clear duration", 32'(n), 32'(DEPTH));
      chk("no ack during clear", 32'(saw_ack), 32'd0);
      ref_clear();
      op("clear word 0", 1'b0, 32'h0, 32'h0, 4'hF);
      op("clear word 4799", 1'b0, 32'(4799 * 4), 32'h0, 4'hF);
      op("clear word 9599", 1'b0, 32'(9599 * 4), 32'h0, 4'hF);

      for (int i = 0; i < 17; i++) begin
         xact(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd, lat, os);
         if (vt[i].we) ref_write(vt[i].adr, vt[i].dat, vt[i].sel);
         chk($sformatf("vec%0d data", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("vec%0d ack width", i), 32'(os), 32'd1);
      end

      // read abandoned while in S_READ: no ack, dat_o untouched
      hold = bus_if.dat_s;
      bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b0; bus_if.adr = 32'h20; bus_if.sel = 4'hF;
      tick;
      bus_if.stb = 1'b0; bus_if.cyc = 1'b0;
      saw_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (bus_if.ack !== 1'b0) saw_ack = 1'b1;
      end
      chk("abort read no ack", 32'(saw_ack), 32'd0);
      chk("abort read dat_o hold", bus_if.dat_s, hold);
      op("read after abort", 1'b0, 32'h20, 32'h0, 4'hF);

      // write abandoned in S_ACK: ack falls with cyc, write stays committed
      bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b1; bus_if.adr = 32'h50;
      bus_if.sel = 4'hF; bus_if.dat_m = 32'h0BADF00D;
      tick;
      bus_if.stb = 1'b0; bus_if.cyc = 1'b0;
      #1;
      chk("abort in ack drops ack", 32'(bus_if.ack), 32'd0);
      ref_write(32'h50, 32'h0BADF00D, 4'hF);
      tick;
      op("aborted write kept", 1'b0, 32'h50, 32'h0, 4'hF);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0: adr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            1: adr = 32'($urandom_range(DEPTH - 8, DEPTH - 1) * 4 + $urandom_range(0, 3));
            2: adr = 32'($urandom_range(DEPTH, DEPTH + 7) * 4);
            3: adr = {$urandom_range(1, 65535), 16'($urandom_range(0, 255) * 4)};
            default: adr = 32'($urandom_range(0, DEPTH - 1) * 4);
         endcase
         op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom));
      end

      // reset while a write sits in S_ACK, then a request held through the whole clear
      bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b1; bus_if.adr = 32'h30;
      bus_if.sel = 4'hF; bus_if.dat_m = 32'h77777777;
      tick;
      bus_if.stb = 1'b0;
      chk("pending ack before reset", 32'(bus_if.ack), 32'd1);
      rst_i = 1'b1;
      tick;
      chk("reset drops ack", 32'(bus_if.ack), 32'd0);
      chk("reset clr_busy again", 32'(clr_busy), 32'd1);
      chk("reset dat_o again", bus_if.dat_s, 32'h0);
      rst_i = 1'b0;
      bus_if.stb = 1'b1; bus_if.adr = 32'h40; bus_if.dat_m = 32'h5A5A5A5A;
      n = 0; n_fall = -1;
      while (bus_if.ack !== 1'b1 && n < 20000) begin
         tick;
         n++;
         if (n_fall < 0 && clr_busy === 1'b0) n_fall = n;
      end
      bus_if.stb = 1'b0;
      chk("held request clr_busy fall", 32'(n_fall), 32'(DEPTH));
      chk("held request ack cycle", 32'(n), 32'(DEPTH + 1));
      tick;
      bus_if.cyc = 1'b0;
      ref_clear();
      ref_write(32'h40, 32'h5A5A5A5A, 4'hF);
      op("write lost to clear", 1'b0, 32'h30, 32'h0, 4'hF);
      op("held write landed", 1'b0, 32'h40, 32'h0, 4'hF);
      op("old data cleared", 1'b0, 32'h20, 32'h0, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
